// File: rtl/muladd_writeback.sv
`default_nettype none
// ============================================================================
// Module   : muladd_writeback
// Brief    : Retires fixed-latency multiply-add results to data memory and/or
//            an outbound FIFO, with issue credit to protect the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module muladd_writeback #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 8,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              issue_valid,
  input  logic              issue_wen,
  input  logic [AWIDTH-1:0] issue_waddr,
  input  logic              issue_out,
  output logic              issue_ready,
  input  logic [DWIDTH-1:0] p,
  output logic              mem_wen,
  output logic [AWIDTH-1:0] mem_waddr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  input  logic              out_ready,
  output logic              err_overflow
);

  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_CW = $clog2(LATENCY + 1);
  localparam int c_SW = c_PW + c_CW + 1;
  localparam logic [c_PW:0]   c_PTR_ONE  = 1;
  localparam logic [c_CW-1:0] c_PEND_ONE = 1;

  logic [LATENCY-1:0] r_tag_valid;
  logic [LATENCY-1:0] r_tag_wen;
  logic [LATENCY-1:0] r_tag_out;
  logic [AWIDTH-1:0]  r_tag_waddr [LATENCY];

  logic [DWIDTH-1:0]  r_fifo [FIFO_DEPTH];
  logic [c_PW:0]      r_wr_ptr;
  logic [c_PW:0]      r_rd_ptr;
  logic [c_CW-1:0]    r_pending;
  logic               r_issue_ready;
  logic               r_mem_wen;
  logic [AWIDTH-1:0]  r_mem_waddr;
  logic [DWIDTH-1:0]  r_mem_wdata;
  logic               r_err_overflow;

  logic               w_ret_wen;
  logic               w_push;
  logic               w_pop;
  logic               w_push_ok;
  logic               w_drop;
  logic               w_empty;
  logic               w_full;
  logic [c_PW:0]      w_count;
  logic [c_PW:0]      w_count_next;
  logic [c_CW-1:0]    w_pending_next;
  logic [c_SW-1:0]    w_credit_sum;

  // Tag stage LATENCY-1 lines up with the result currently on p.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_tag_valid <= '0;
      r_tag_wen   <= '0;
      r_tag_out   <= '0;
      for (int i = 0; i < LATENCY; i++) r_tag_waddr[i] <= '0;
    end else begin
      r_tag_valid[0] <= issue_valid;
      r_tag_wen[0]   <= issue_wen & issue_valid;
      r_tag_out[0]   <= issue_out & issue_valid;
      r_tag_waddr[0] <= issue_waddr;
      for (int i = 1; i < LATENCY; i++) begin
        r_tag_valid[i] <= r_tag_valid[i-1];
        r_tag_wen[i]   <= r_tag_wen[i-1];
        r_tag_out[i]   <= r_tag_out[i-1];
        r_tag_waddr[i] <= r_tag_waddr[i-1];
      end
    end
  end

  assign w_ret_wen = r_tag_valid[LATENCY-1] & r_tag_wen[LATENCY-1];
  assign w_push    = r_tag_valid[LATENCY-1] & r_tag_out[LATENCY-1];

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (w_count == (c_PW+1)'(FIFO_DEPTH));
  assign w_pop     = ~w_empty & out_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  always_comb begin
    w_count_next   = w_count;
    w_pending_next = r_pending;
    if (w_push_ok) w_count_next = w_count_next + c_PTR_ONE;
    if (w_pop)     w_count_next = w_count_next - c_PTR_ONE;
    if (issue_valid & issue_out) w_pending_next = w_pending_next + c_PEND_ONE;
    if (w_push)                  w_pending_next = w_pending_next - c_PEND_ONE;
    w_credit_sum = {{(c_SW-c_PW-1){1'b0}}, w_count_next}
                 + {{(c_SW-c_CW){1'b0}}, w_pending_next};
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_pending      <= '0;
      r_issue_ready  <= 1'b1;
      r_err_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_fifo[r_wr_ptr[c_PW-1:0]] <= p;
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      if (w_drop) r_err_overflow <= 1'b1;
      r_pending     <= w_pending_next;
      r_issue_ready <= (w_credit_sum < c_SW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_mem_wen   <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_wen <= w_ret_wen;
      if (w_ret_wen) begin
        r_mem_waddr <= r_tag_waddr[LATENCY-1];
        r_mem_wdata <= p;
      end
    end
  end

  assign issue_ready  = r_issue_ready;
  assign mem_wen      = r_mem_wen;
  assign mem_waddr    = r_mem_waddr;
  assign mem_wdata    = r_mem_wdata;
  assign out_valid    = ~w_empty;
  assign out_data     = r_fifo[r_rd_ptr[c_PW-1:0]];
  assign err_overflow = r_err_overflow;

endmodule
`default_nettype wire

// File: tb/tb_muladd_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_muladd_writeback
// Brief    : Directed, table-driven self-checking bench for muladd_writeback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muladd_writeback;

  localparam int c_LAT = 3;

  logic        clk = 1'b0;
  logic        Resetn = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_wen = 1'b0;
  logic [7:0]  issue_waddr = '0;
  logic        issue_out = 1'b0;
  logic        issue_ready;
  logic [31:0] p = '0;
  logic        mem_wen;
  logic [7:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        err_overflow;

  int checks = 0;
  int failures = 0;

  logic [31:0] pipe [c_LAT];
  logic [31:0] in_data = 32'hBAD0_0000;

  typedef struct {
    logic        wen;
    logic [7:0]  waddr;
    logic        out;
    logic [31:0] data;
    logic        exp_mem_wen;
    logic        exp_out_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [5];

  muladd_writeback #(
    .DWIDTH(32), .AWIDTH(8), .LATENCY(c_LAT), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .Resetn(Resetn),
    .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_waddr(issue_waddr), .issue_out(issue_out),
    .issue_ready(issue_ready), .p(p),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Upstream multiply-add stand-in: the value issued in cycle t is on p in t+LAT.
  task automatic step();
    @(posedge clk);
    for (int i = c_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = in_data;
    #1;
    p = pipe[c_LAT-1];
  endtask

  task automatic issue(input logic wen, input logic [7:0] a, input logic o,
                       input logic [31:0] d);
    issue_valid = 1'b1; issue_wen = wen; issue_waddr = a; issue_out = o;
    in_data = d;
    step();
    issue_valid = 1'b0; issue_wen = 1'b0; issue_out = 1'b0;
    in_data = 32'hBAD0_0000;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mem_wen"}, mem_wen, 0);
    chk({tag, "_mem_waddr"}, mem_waddr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_err"}, err_overflow, 0);
    chk({tag, "_ready"}, issue_ready, 1);
  endtask

  task automatic fill_fifo(input logic [31:0] base);
    for (int k = 0; k < 4; k++) issue(1'b0, 8'h00, 1'b1, base + 32'(k));
  endtask

  initial begin
    int acc;
    for (int i = 0; i < c_LAT; i++) pipe[i] = '0;

    vecs[0] = '{1'b1, 8'h12, 1'b0, 32'h0000_0007, 1'b1, 1'b0, 32'h0000_0007};
    vecs[1] = '{1'b1, 8'h34, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 8'h56, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b1, 32'h0BAD_F00D};
    vecs[3] = '{1'b0, 8'h78, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678};
    vecs[4] = '{1'b1, 8'hFF, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF};

    // Reset state, during and after reset
    step(); step();
    chk_idle_outputs("in_reset");
    Resetn = 1'b1;
    step();
    chk_idle_outputs("after_reset");

    // Single-op routing table
    foreach (vecs[v]) begin
      issue(vecs[v].wen, vecs[v].waddr, vecs[v].out, vecs[v].data);
      step(); step();
      chk("vec_early_mem_wen", mem_wen, 0);
      chk("vec_early_out_valid", out_valid, 0);
      step();
      chk("vec_mem_wen", mem_wen, vecs[v].exp_mem_wen);
      if (vecs[v].exp_mem_wen) begin
        chk("vec_mem_waddr", mem_waddr, vecs[v].waddr);
        chk("vec_mem_wdata", mem_wdata, vecs[v].exp_data);
      end
      chk("vec_out_valid", out_valid, vecs[v].exp_out_valid);
      if (vecs[v].exp_out_valid) begin
        chk("vec_out_data", out_data, vecs[v].exp_data);
        out_ready = 1'b1;
      end
      step();
      out_ready = 1'b0;
      chk("vec_late_mem_wen", mem_wen, 0);
      chk("vec_late_out_valid", out_valid, 0);
    end

    // Back-to-back memory retires
    issue(1'b1, 8'h21, 1'b0, 32'h111);
    issue(1'b1, 8'h22, 1'b0, 32'h222);
    issue(1'b1, 8'h23, 1'b0, 32'h333);
    chk("b2b_pre_wen", mem_wen, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("b2b_wen", mem_wen, 1);
      chk("b2b_waddr", mem_waddr, 8'h21 + 8'(k));
      chk("b2b_wdata", mem_wdata, 32'h111 * 32'(k + 1));
    end
    step();
    chk("b2b_post_wen", mem_wen, 0);

    // Credit throttle
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      if (issue_ready) begin
        issue(1'b0, 8'h00, 1'b1, 32'hA0 + 32'(acc));
        acc++;
      end else begin
        step();
      end
    end
    chk("thr_accepted", acc, 4);
    chk("thr_ready", issue_ready, 0);
    chk("thr_err", err_overflow, 0);
    chk("thr_out_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("thr_pop_data", out_data, 32'hA0 + 32'(k));
      step();
      if (k == 0) chk("thr_ready_after_pop", issue_ready, 1);
    end
    out_ready = 1'b0;
    chk("thr_drained", out_valid, 0);

    // Full FIFO with simultaneous push and pop
    fill_fifo(32'hB0);
    chk("pp_ready_full", issue_ready, 0);
    issue(1'b0, 8'h00, 1'b1, 32'hB4);
    step(); step();
    chk("pp_head_before", out_data, 32'hB0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pp_head_after", out_data, 32'hB1);
    chk("pp_err", err_overflow, 0);
    chk("pp_ready_still_full", issue_ready, 0);
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      chk("pp_order", out_data, 32'hB0 + 32'(k));
      step();
    end
    out_ready = 1'b0;
    chk("pp_drained", out_valid, 0);
    chk("pp_err_end", err_overflow, 0);

    // Credit violation: push into a full FIFO is dropped
    fill_fifo(32'hC0);
    issue(1'b0, 8'h00, 1'b1, 32'hC4);
    step(); step(); step();
    chk("ovf_err", err_overflow, 1);
    chk("ovf_head", out_data, 32'hC0);
    step(); step();
    chk("ovf_err_held", err_overflow, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("ovf_order", out_data, 32'hC0 + 32'(k));
      step();
    end
    out_ready = 1'b0;
    chk("ovf_dropped", out_valid, 0);
    chk("ovf_err_after_drain", err_overflow, 1);

    // Reset with ops in flight
    issue(1'b1, 8'h40, 1'b1, 32'hD0);
    issue(1'b1, 8'h41, 1'b1, 32'hD1);
    issue(1'b1, 8'h42, 1'b1, 32'hD2);
    Resetn = 1'b0;
    #1;
    chk("rst_err_cleared", err_overflow, 0);
    step();
    Resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("rst_mem_wen", mem_wen, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ready", issue_ready, 1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
